// File: rtl/cpri_tx_pkg.sv
// rtl/cpri_tx_pkg.sv - shared state encoding, widths and round-robin helper for the CPRI TX framer
package cpri_tx_pkg;

    localparam logic [1:0] ST_ARB   = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int MAX_CH = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_sel_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requesting channel after ptr, wrapping modulo n.
    function automatic rr_sel_t rr_next(input logic [MAX_CH-1:0] req, input int ptr, input int n);
        rr_sel_t sel;
        int      c;
        sel = '0;
        for (int k = 1; k <= MAX_CH; k++) begin
            c = (ptr + k) % n;
            if (!sel.found && k <= n && req[c[4:0]]) begin
                sel.found = 1'b1;
                sel.idx   = c[4:0];
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/cpri_pp_buf.sv
// rtl/cpri_pp_buf.sv - per-channel ping-pong packet buffer with drop-on-overflow write side
module cpri_pp_buf #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 7,
    parameter int RD_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wlast,
    input  logic              rd_done,
    input  logic [ADDR_W-1:0] raddr,
    output logic [1:0]        full,
    output logic              rb,
    output logic              ovf,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2*(2**ADDR_W)];
    logic [DATA_W-1:0] pipe [RD_LAT];
    logic              wb;
    logic              drop;
    logic              ovf_q;
    logic              wr_ok;
    logic              drop_hit;

    assign wr_ok    = wen && !drop && !full[wb];
    assign drop_hit = wen && !drop && full[wb];
    assign ovf      = ovf_q | drop_hit;
    assign rdata    = pipe[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[{wb, waddr}] <= wdata;
        end
    end

    // A set (write side) and a clear (read side) never target the same bank in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= '0;
            wb    <= 1'b0;
            rb    <= 1'b0;
            drop  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_ok && wlast) begin
                full[wb] <= 1'b1;
                wb       <= ~wb;
            end
            if (rd_done) begin
                full[rb] <= 1'b0;
                rb       <= ~rb;
            end
            if (drop_hit) begin
                ovf_q <= 1'b1;
                drop  <= !wlast;
            end else if (drop && wen && wlast) begin
                drop <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= mem[{rb, raddr}];
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

endmodule

// File: rtl/cpri_tx_framer.sv
// rtl/cpri_tx_framer.sv - round-robin payload reader merging per-channel packet buffers onto one IQ TX stream
module cpri_tx_framer import cpri_tx_pkg::*; #(
    parameter int  DATA_W  = 64,
    parameter int  ADDR_W  = 7,
    parameter int  PKT_LEN = 99,
    parameter int  HDR_LEN = 3,
    parameter int  NUM_CH  = 2,
    parameter int  RD_LAT  = 3,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        i_cpri_wen,
    input  logic [NUM_CH*ADDR_W-1:0] i_cpri_waddr,
    input  logic [NUM_CH*DATA_W-1:0] i_cpri_wdata,
    input  logic [NUM_CH-1:0]        i_cpri_wlast,
    input  logic                     i_iq_tx_enable,
    output logic                     o_iq_tx_valid,
    output logic [DATA_W-1:0]        o_iq_tx_data,
    output logic                     o_iq_tx_sop,
    output logic                     o_iq_tx_eop,
    output logic [CH_W-1:0]          o_iq_tx_chan,
    output logic [NUM_CH-1:0]        o_ovf
);

    localparam int DC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int SB_W = CH_W + 3;

    logic [1:0]        state;
    logic [CH_W-1:0]   sel_ch;
    logic [CH_W-1:0]   rr_ptr;
    logic [ADDR_W-1:0] raddr;
    logic [DC_W-1:0]   drain_cnt;

    logic [1:0]        buf_full  [NUM_CH];
    logic [DATA_W-1:0] buf_rdata [NUM_CH];
    logic [NUM_CH-1:0] buf_rb;
    logic [NUM_CH-1:0] rd_done;

    logic [MAX_CH-1:0] req;
    rr_sel_t           pick;
    logic              issue;
    logic              last_addr;
    logic              drain_end;

    logic [SB_W-1:0]   sb [RD_LAT];
    logic [SB_W-1:0]   sb_in;
    logic [SB_W-1:0]   sb_out;
    logic [CH_W-1:0]   out_ch;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cpri_pp_buf #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .RD_LAT (RD_LAT)
        ) u_buf (
            .clk     (clk),
            .rst     (rst),
            .wen     (i_cpri_wen[c]),
            .waddr   (i_cpri_waddr[c*ADDR_W +: ADDR_W]),
            .wdata   (i_cpri_wdata[c*DATA_W +: DATA_W]),
            .wlast   (i_cpri_wlast[c]),
            .rd_done (rd_done[c]),
            .raddr   (raddr),
            .full    (buf_full[c]),
            .rb      (buf_rb[c]),
            .ovf     (o_ovf[c]),
            .rdata   (buf_rdata[c])
        );
    end

    always_comb begin
        req = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            req[c] = buf_full[c][buf_rb[c]];
        end
        pick      = rr_next(req, int'(rr_ptr), NUM_CH);
        issue     = (state == ST_READ);
        last_addr = (raddr == ADDR_W'(PKT_LEN - 1));
        drain_end = (state == ST_DRAIN) && (drain_cnt == DC_W'(RD_LAT - 1));
        rd_done   = '0;
        if (drain_end) begin
            rd_done[sel_ch] = 1'b1;
        end
        sb_in = issue ? {1'b1, (raddr == ADDR_W'(HDR_LEN)), last_addr, sel_ch} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ARB;
            sel_ch    <= '0;
            rr_ptr    <= CH_W'(NUM_CH - 1);
            raddr     <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (i_iq_tx_enable && pick.found) begin
                        sel_ch <= pick.idx[CH_W-1:0];
                        rr_ptr <= pick.idx[CH_W-1:0];
                        raddr  <= ADDR_W'(HDR_LEN);
                        state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (last_addr) begin
                        drain_cnt <= '0;
                        state     <= ST_DRAIN;
                    end else begin
                        raddr <= raddr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_end) begin
                        state <= ST_ARB;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

    // Sideband travels with the RAM read pipeline so valid/sop/eop/chan line up with data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[0] <= sb_in;
            for (int i = 1; i < RD_LAT; i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    assign sb_out        = sb[RD_LAT-1];
    assign out_ch        = sb_out[CH_W-1:0];
    assign o_iq_tx_valid = sb_out[SB_W-1];
    assign o_iq_tx_sop   = sb_out[SB_W-2];
    assign o_iq_tx_eop   = sb_out[SB_W-3];
    assign o_iq_tx_chan  = out_ch;
    assign o_iq_tx_data  = o_iq_tx_valid ? buf_rdata[out_ch] : '0;

endmodule
